// File: rtl/cache_assoc2_if.sv
// Bus bundle between the CPU bus master and cache_assoc2: lookup/fill request
// signals in, cached word / hit / ready flags out.
interface cache_assoc2_if;
  logic        I_en;
  logic        I_offer_data;
  logic [2:0]  I_busop;
  logic [31:0] I_addr;
  logic [31:0] I_invalidate_addr;
  logic [31:0] I_data;
  logic [31:0] O_data;
  logic        O_hit;
  logic        O_ready;

  modport master (
    output I_en, I_offer_data, I_busop, I_addr, I_invalidate_addr, I_data,
    input  O_data, O_hit, O_ready
  );

  modport slave (
    input  I_en, I_offer_data, I_busop, I_addr, I_invalidate_addr, I_data,
    output O_data, O_hit, O_ready
  );
endinterface

// File: rtl/cache_assoc2.sv
// cache_assoc2: 2-way set-associative, read-allocate word cache with one LRU
// bit per set, invalidation of a whole set on any write into the cacheable
// window, and an internal sequencer that clears all sets after reset.
module cache_assoc2 #(
  parameter int SETS        = 128,
  parameter int CACHE_ABITS = 25
) (
  input logic           I_clk,
  input logic           I_reset,
  cache_assoc2_if.slave bus
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = CACHE_ABITS - 2 - IDX;

  localparam logic [2:0] BUSOP_READW  = 3'b100;
  localparam logic [2:0] BUSOP_WRITEB = 3'b101;
  localparam logic [2:0] BUSOP_WRITEH = 3'b110;
  localparam logic [2:0] BUSOP_WRITEW = 3'b111;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_r, state_nx_s;
  logic [IDX-1:0]   clr_cnt_r;

  // Per-set storage; lru_r = 0 means way0 is the least recently used way.
  logic             valid0_r [SETS];
  logic             valid1_r [SETS];
  logic             lru_r    [SETS];
  logic [TAGW-1:0]  tag0_r   [SETS];
  logic [TAGW-1:0]  tag1_r   [SETS];
  logic [31:0]      data0_r  [SETS];
  logic [31:0]      data1_r  [SETS];

  // Way state captured at the last lookup edge; O_hit is evaluated against it.
  logic             snap_v0_r, snap_v1_r;
  logic [TAGW-1:0]  snap_t0_r, snap_t1_r;
  logic [31:0]      o_data_r;

  logic [IDX-1:0]   idx_s, inv_idx_s;
  logic [TAGW-1:0]  tag_s;
  logic             ready_s, cacheable_read_s, inv_req_s;
  logic             snap_hit0_s, snap_hit1_s, hit_s, hit_way_s;
  logic             arr_hit0_s, arr_hit1_s;
  logic             clr_we_s, inv_we_s, alloc_s, data_we_s, wr_way_s;
  logic             lru_we_s, lru_val_s, victim_s;
  logic             unused_inv_s;

  assign idx_s     = bus.I_addr[IDX+1:2];
  assign tag_s     = bus.I_addr[CACHE_ABITS-1:IDX+2];
  assign inv_idx_s = bus.I_invalidate_addr[IDX+1:2];
  assign ready_s   = (state_r == ST_RUN);

  assign cacheable_read_s = (bus.I_addr[31:CACHE_ABITS] == {(32-CACHE_ABITS){1'b0}}) &&
                            (bus.I_addr[1:0] == 2'b00) && (bus.I_busop == BUSOP_READW);

  // Any sub-word write touches the word's set, so tag and byte offset are irrelevant.
  assign inv_req_s = (bus.I_invalidate_addr[31:CACHE_ABITS] == {(32-CACHE_ABITS){1'b0}}) &&
                     ((bus.I_busop == BUSOP_WRITEB) || (bus.I_busop == BUSOP_WRITEH) ||
                      (bus.I_busop == BUSOP_WRITEW));
  assign unused_inv_s = ^{bus.I_invalidate_addr[CACHE_ABITS-1:IDX+2], bus.I_invalidate_addr[1:0]};

  assign snap_hit0_s = snap_v0_r && (snap_t0_r == tag_s);
  assign snap_hit1_s = snap_v1_r && (snap_t1_r == tag_s);
  assign hit_s       = ready_s && cacheable_read_s && (snap_hit0_s || snap_hit1_s);
  assign hit_way_s   = ~snap_hit0_s;

  assign arr_hit0_s  = valid0_r[idx_s] && (tag0_r[idx_s] == tag_s);
  assign arr_hit1_s  = valid1_r[idx_s] && (tag1_r[idx_s] == tag_s);

  assign bus.O_data  = o_data_r;
  assign bus.O_hit   = hit_s;
  assign bus.O_ready = ready_s;

  // FSM state register.
  always_ff @(posedge I_clk) begin
    if (I_reset) state_r <= ST_CLEAR;
    else         state_r <= state_nx_s;
  end

  // FSM next state: leave CLEAR once the last set has been cleared.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == IDX'(SETS - 1)) state_nx_s = ST_RUN;
        else                             state_nx_s = ST_CLEAR;
      end
      ST_RUN:  state_nx_s = ST_RUN;
      default: state_nx_s = ST_CLEAR;
    endcase
  end

  // Replacement victim from the captured way state: invalid way0, then invalid way1, then LRU.
  always_comb begin
    victim_s = 1'b0;
    if (!snap_v0_r)      victim_s = 1'b0;
    else if (!snap_v1_r) victim_s = 1'b1;
    else                 victim_s = lru_r[idx_s];
  end

  // Array write control with priority reset > clear > invalidate > fill/LRU.
  always_comb begin
    clr_we_s  = 1'b0;
    inv_we_s  = 1'b0;
    alloc_s   = 1'b0;
    data_we_s = 1'b0;
    wr_way_s  = 1'b0;
    lru_we_s  = 1'b0;
    lru_val_s = 1'b0;
    if (I_reset) begin
      clr_we_s = 1'b0;
    end else if (!ready_s) begin
      clr_we_s = 1'b1;
    end else if (inv_req_s) begin
      inv_we_s = 1'b1;
    end else if (bus.I_en && hit_s) begin
      lru_we_s  = 1'b1;
      lru_val_s = ~hit_way_s;
      data_we_s = bus.I_offer_data;
      wr_way_s  = hit_way_s;
    end else if (bus.I_en && bus.I_offer_data && cacheable_read_s) begin
      alloc_s   = 1'b1;
      data_we_s = 1'b1;
      wr_way_s  = victim_s;
      lru_we_s  = 1'b1;
      lru_val_s = ~victim_s;
    end else begin
      lru_we_s = 1'b0;
    end
  end

  // Valid/tag/LRU arrays: clear sweep, set invalidation, allocation and LRU update.
  always_ff @(posedge I_clk) begin
    if (clr_we_s) begin
      valid0_r[clr_cnt_r] <= 1'b0;
      valid1_r[clr_cnt_r] <= 1'b0;
      lru_r[clr_cnt_r]    <= 1'b0;
    end else if (inv_we_s) begin
      valid0_r[inv_idx_s] <= 1'b0;
      valid1_r[inv_idx_s] <= 1'b0;
    end else begin
      if (alloc_s) begin
        if (wr_way_s) begin
          valid1_r[idx_s] <= 1'b1;
          tag1_r[idx_s]   <= tag_s;
        end else begin
          valid0_r[idx_s] <= 1'b1;
          tag0_r[idx_s]   <= tag_s;
        end
      end
      if (lru_we_s) lru_r[idx_s] <= lru_val_s;
    end
  end

  // Data arrays are never cleared; validity alone decides whether they are used.
  always_ff @(posedge I_clk) begin
    if (data_we_s) begin
      if (wr_way_s) data1_r[idx_s] <= bus.I_data;
      else          data0_r[idx_s] <= bus.I_data;
    end
  end

  // Clear counter, lookup capture and registered output word.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      clr_cnt_r <= {IDX{1'b0}};
      o_data_r  <= 32'h0000_0000;
      snap_v0_r <= 1'b0;
      snap_v1_r <= 1'b0;
    end else if (!ready_s) begin
      clr_cnt_r <= clr_cnt_r + 1'b1;
      snap_v0_r <= 1'b0;
      snap_v1_r <= 1'b0;
    end else if (bus.I_en) begin
      snap_v0_r <= valid0_r[idx_s];
      snap_v1_r <= valid1_r[idx_s];
      snap_t0_r <= tag0_r[idx_s];
      snap_t1_r <= tag1_r[idx_s];
      if (arr_hit0_s)      o_data_r <= data0_r[idx_s];
      else if (arr_hit1_s) o_data_r <= data1_r[idx_s];
    end
  end
endmodule

// File: tb/tb_cache_assoc2.sv
// Bench for cache_assoc2: two instances (128 sets / 25-bit window and
// 2 sets / 16-bit window) share one stimulus stream; a recency-list model per
// instance predicts hit/data, expectations go to per-instance queues and a
// negedge monitor pops and compares them.
module tb_cache_assoc2;
  localparam logic [2:0] BOP_READB  = 3'b000;
  localparam logic [2:0] BOP_READW  = 3'b100;
  localparam logic [2:0] BOP_WRITEB = 3'b101;
  localparam logic [2:0] BOP_WRITEH = 3'b110;
  localparam logic [2:0] BOP_WRITEW = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, offer = 1'b0, chk_en = 1'b0;
  logic [2:0]  busop = BOP_READB;
  logic [31:0] addr = 32'h0, inv_addr = 32'h0, wdata = 32'h0;
  logic [31:0] obs_addr = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_assoc2_if bus_a();
  cache_assoc2_if bus_b();

  assign bus_a.I_en = en;            assign bus_b.I_en = en;
  assign bus_a.I_offer_data = offer; assign bus_b.I_offer_data = offer;
  assign bus_a.I_busop = busop;      assign bus_b.I_busop = busop;
  assign bus_a.I_addr = addr;        assign bus_b.I_addr = addr;
  assign bus_a.I_invalidate_addr = inv_addr;
  assign bus_b.I_invalidate_addr = inv_addr;
  assign bus_a.I_data = wdata;       assign bus_b.I_data = wdata;

  cache_assoc2 #(.SETS(128), .CACHE_ABITS(25)) dut_a (.I_clk(clk), .I_reset(rst), .bus(bus_a));
  cache_assoc2 #(.SETS(2),   .CACHE_ABITS(16)) dut_b (.I_clk(clk), .I_reset(rst), .bus(bus_b));

  // Reference model: each set is a list of resident words, most recent first, at most two.
  typedef struct { int unsigned waddr; logic [31:0] data; } ent_t;
  typedef struct { bit hit; logic [31:0] data; } exp_t;

  ent_t        mdl [2][128][$];
  exp_t        exp_q [2][$];
  int unsigned m_sets  [2] = '{128, 2};
  int unsigned m_abits [2] = '{25, 16};

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  function automatic bit m_window(int m, logic [31:0] a);
    return (a >> m_abits[m]) == 32'd0;
  endfunction

  function automatic bit m_cacheable(int m, logic [31:0] a, logic [2:0] op);
    return m_window(m, a) && (a % 4 == 0) && (op == BOP_READW);
  endfunction

  function automatic int m_set(int m, logic [31:0] a);
    return int'((a / 4) % m_sets[m]);
  endfunction

  function automatic int m_find(int m, logic [31:0] a);
    int s = m_set(m, a);
    for (int i = 0; i < mdl[m][s].size(); i++)
      if (mdl[m][s][i].waddr == a / 4) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < 128; s++) mdl[m][s].delete();
  endtask

  // Count edges from reset release until each instance reports ready.
  task automatic measure_clear(input int req_a, input int req_b);
    int ca = -1, cb = -1;
    for (int c = 0; c < 400; c++) begin
      if (bus_a.O_ready && ca < 0) ca = c;
      if (bus_b.O_ready && cb < 0) cb = c;
      if (ca >= 0 && cb >= 0) break;
      step();
    end
    check("clear_cycles_a", ca, req_a);
    check("clear_cycles_b", cb, req_b);
  endtask

  // One read: a capture edge (READB, no side effects), then the observed
  // cycle with the real busop ending in a commit edge that may fill.
  task automatic read_txn(input logic [31:0] a, input logic [2:0] op, input bit fill,
                          input logic [31:0] d);
    int pos [2];
    addr = a; busop = BOP_READB; en = 1'b1; offer = 1'b0;
    step();
    for (int m = 0; m < 2; m++) begin
      exp_t e;
      pos[m] = m_cacheable(m, a, op) ? m_find(m, a) : -1;
      e.hit  = (pos[m] >= 0);
      e.data = e.hit ? mdl[m][m_set(m, a)][pos[m]].data : 32'h0;
      exp_q[m].push_back(e);
    end
    obs_addr = a; busop = op; offer = fill; wdata = d; en = 1'b1; chk_en = 1'b1;
    step();
    chk_en = 1'b0; en = 1'b0; offer = 1'b0; busop = BOP_READB;
    for (int m = 0; m < 2; m++) begin
      int s = m_set(m, a);
      ent_t e;
      if (m_cacheable(m, a, op)) begin
        if (pos[m] >= 0) begin
          e = mdl[m][s][pos[m]];
          mdl[m][s].delete(pos[m]);
          if (fill) e.data = d;
          mdl[m][s].push_front(e);
        end else if (fill) begin
          if (mdl[m][s].size() >= 2) void'(mdl[m][s].pop_back());
          e.waddr = a / 4;
          e.data  = d;
          mdl[m][s].push_front(e);
        end
      end
    end
  endtask

  task automatic inv_txn(input logic [31:0] a, input logic [2:0] op);
    inv_addr = a; busop = op; en = 1'b0;
    step();
    busop = BOP_READB;
    for (int m = 0; m < 2; m++)
      if (m_window(m, a) && (op == BOP_WRITEB || op == BOP_WRITEH || op == BOP_WRITEW))
        mdl[m][m_set(m, a)].delete();
  endtask

  // Monitor: compare each observed cycle against the queued expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        logic        hit_v;
        logic [31:0] data_v;
        exp_t        e;
        hit_v  = (m == 0) ? bus_a.O_hit  : bus_b.O_hit;
        data_v = (m == 0) ? bus_a.O_data : bus_b.O_data;
        if (exp_q[m].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_%0d: output with no expectation at addr %h", m, obs_addr);
        end else begin
          e = exp_q[m].pop_front();
          check($sformatf("hit_%0d@%h", m, obs_addr), {31'd0, hit_v}, {31'd0, e.hit});
          if (e.hit) check($sformatf("data_%0d@%h", m, obs_addr), data_v, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] pool_addr();
    return (32'($urandom_range(0, 7)) << 9) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    logic [2:0] wops [4];
    wops = '{BOP_WRITEB, BOP_WRITEH, BOP_WRITEW, BOP_READW};

    do_reset();
    check("rst_ready_a", {31'd0, bus_a.O_ready}, 32'd0);
    check("rst_hit_a",   {31'd0, bus_a.O_hit},   32'd0);
    check("rst_data_a",  bus_a.O_data,           32'd0);
    check("rst_ready_b", {31'd0, bus_b.O_ready}, 32'd0);
    check("rst_hit_b",   {31'd0, bus_b.O_hit},   32'd0);
    check("rst_data_b",  bus_b.O_data,           32'd0);
    measure_clear(128, 2);

    // Reset reasserted part-way through the clear restarts the count.
    do_reset();
    repeat (60) step();
    check("mid_clear_ready_a", {31'd0, bus_a.O_ready}, 32'd0);
    do_reset();
    measure_clear(128, 2);

    // Miss, fill, hit; uncacheable read never fills.
    read_txn(32'h0000_0100, BOP_READW, 1'b1, 32'hDEAD_BEEF);
    read_txn(32'h0000_0100, BOP_READW, 1'b0, 32'h0);
    read_txn(32'h0200_0100, BOP_READW, 1'b1, 32'h1111_1111);
    read_txn(32'h0200_0100, BOP_READW, 1'b0, 32'h0);

    // Two-way conflict and LRU eviction.
    read_txn(32'h0000_0300, BOP_READW, 1'b1, 32'hBBBB_0300);
    read_txn(32'h0000_0300, BOP_READW, 1'b0, 32'h0);
    read_txn(32'h0000_0100, BOP_READW, 1'b0, 32'h0);
    read_txn(32'h0000_0500, BOP_READW, 1'b1, 32'hCCCC_0500);
    read_txn(32'h0000_0100, BOP_READW, 1'b0, 32'h0);
    read_txn(32'h0000_0500, BOP_READW, 1'b0, 32'h0);
    read_txn(32'h0000_0300, BOP_READW, 1'b0, 32'h0);

    // Invalidate a full set, leaving a neighbouring set intact.
    read_txn(32'h0000_0300, BOP_READW, 1'b1, 32'hBBBB_0300);
    read_txn(32'h0000_0100, BOP_READW, 1'b1, 32'hAAAA_0100);
    read_txn(32'h0000_0104, BOP_READW, 1'b1, 32'hDDDD_0104);
    inv_txn(32'h0000_0103, BOP_WRITEB);
    read_txn(32'h0000_0100, BOP_READW, 1'b0, 32'h0);
    read_txn(32'h0000_0300, BOP_READW, 1'b0, 32'h0);
    read_txn(32'h0000_0104, BOP_READW, 1'b0, 32'h0);

    // Misaligned and non-word reads do not hit or change state.
    read_txn(32'h0000_0100, BOP_READW, 1'b1, 32'hAAAA_0100);
    read_txn(32'h0000_0102, BOP_READW, 1'b1, 32'h5555_5555);
    read_txn(32'h0000_0100, BOP_READB, 1'b1, 32'h6666_6666);
    read_txn(32'h0000_0100, BOP_READW, 1'b0, 32'h0);

    // Randomised traffic over a small conflicting address pool.
    for (int t = 0; t < 400; t++) begin
      int          r = int'($urandom_range(0, 99));
      logic [31:0] a = pool_addr();
      if (r < 12) begin
        a = a | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) a = a | 32'h0200_0000;
        inv_txn(a, wops[$urandom_range(0, 3)]);
      end else begin
        if (r < 20)      a = a | 32'h0000_0002;
        else if (r < 28) a = a | 32'h0200_0000;
        else if (r < 32) a = a | 32'h0001_0000;
        read_txn(a, (r >= 32 && r < 36) ? BOP_READB : BOP_READW,
                 $urandom_range(0, 99) < 60, $urandom);
      end
    end

    // A late reset empties the cache.
    do_reset();
    measure_clear(128, 2);
    read_txn(32'h0000_0100, BOP_READW, 1'b0, 32'h0);

    step();
    check("exp_q_drained", exp_q[0].size() + exp_q[1].size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_assoc2.md
Name: cache_assoc2

Overview:
- Parametrised successor to the CPU's direct-mapped word cache: 2-way set-associative, read-allocate, word-granular, with per-set LRU replacement.
- Sits between the CPU bus master and the memory bus. Serves aligned word reads (BUSOP_READW) from low memory and invalidates on any write.
- Replaces the "hold reset for N clocks" clearing scheme with an internal clear sequencer and a ready flag.

Parameters:
- SETS, 128, number of sets; power of two, 2..1024; IDX = log2(SETS).
- CACHE_ABITS, 25, cacheable window is I_addr[31:CACHE_ABITS]==0; TAGW = CACHE_ABITS-2-IDX (must be ≥1).

Ports:
- I_clk  in  1  clock, all state changes on rising edge.
- I_reset  in  1  synchronous, active-high reset; starts/restarts clear sequence.
- I_en  in  1  lookup/fill enable for current bus cycle.
- I_offer_data  in  1  I_data holds valid memory read data for I_addr.
- I_busop  in  3  bus operation code (busdefs encoding).
- I_addr  in  32  read address.
- I_invalidate_addr  in  32  write address to invalidate.
- I_data  in  32  fill data.
- O_data  out  32  cached word from hitting way.
- O_hit  out  1  combinational hit indication.
- O_ready  out  1  clear sequence complete; cache operational.

Behaviour:
- Address split: index = I_addr[IDX+1:2], tag = I_addr[CACHE_ABITS-1:IDX+2].
- cacheable_read = (I_addr[31:CACHE_ABITS]==0) && (I_addr[1:0]==0) && (I_busop==BUSOP_READW).
- Storage per set: way0/way1 each {valid, TAGW tag, 32-bit data}; 1 LRU bit (0 = way0 least recent).
- FSM states CLEAR, RUN.
  - I_reset=1 at any edge: state<=CLEAR, clear counter<=0, O_data<=0. Also applies mid-clear and in RUN.
  - CLEAR: each edge clears valid bits of both ways and the LRU bit of set[counter], then counter++. After set SETS-1 is cleared, state<=RUN. Takes exactly SETS cycles after reset deasserts; data RAM is not cleared.
  - O_ready = (state==RUN). During CLEAR: O_hit=0, no fills, invalidates ignored (sets are being cleared anyway).
- Lookup (RUN): at an edge with I_en=1, register both ways' {valid, tag, data} of set[index]. O_data is registered from the hitting way; way0 has priority if both match (illegal state, must not occur).
- O_hit = O_ready && cacheable_read && ((v0 && t0==tag) || (v1 && t1==tag)), using the registered way state and the current I_addr. The bus holds I_addr/I_busop stable from the I_en edge through consumption, so the result is valid the cycle after the I_en edge.
- LRU update: at any RUN edge with I_en && O_hit, LRU<=~hit_way (the other way becomes LRU).
- Fill: at a RUN edge with I_en && I_offer_data && cacheable_read && !O_hit, write {1, tag, I_data} to the victim way. Set LRU<=~victim.
  - Victim priority, from registered state: invalid way0 > invalid way1 > LRU way.
  - Fill with O_hit=1 rewrites the hitting way's data (no allocation).
- Invalidate: when I_invalidate_addr[31:CACHE_ABITS]==0 and I_busop ∈ {WRITEB, WRITEH, WRITEW}, at the edge clear the valid bits of BOTH ways of set[I_invalidate_addr[IDX+1:2]], independent of I_en. The LRU bit is unchanged.
- Priority: reset > clear > invalidate > fill/LRU. Fill and invalidate are mutually exclusive by busop.
- Reset values: O_data=0, O_hit=0, O_ready=0 (until SETS cycles after reset release).
- Uncacheable or misaligned reads: O_hit=0, no fill, no LRU change.

Test Plan:
- Clear timing (SETS=128): reset for 1 cycle → O_ready=0 for exactly 128 cycles after release, then 1. Reassert reset at clear cycle 60 → count restarts, O_ready rises 128 cycles after second release.
- Miss/fill/hit: READW 0x00000100 miss, fill 0xDEADBEEF → re-read gives O_hit=1, O_data=0xDEADBEEF. A read of 0x02000100 (outside window) gives O_hit=0 with no fill.
- Two-way conflict: fill 0x100=A, 0x300 (wait: same set requires stride SETS*4=0x200) 0x300=B → both hit. Read 0x100 (hit), then fill 0x500=C → evicts 0x300 (LRU). 0x100 and 0x500 hit, 0x300 misses.
- Invalidate: after both ways of set 0x40 are filled, WRITEB to 0x00000103 → both 0x100 and 0x300 miss next lookup. Other sets are unaffected.
- Misaligned/non-word: READW 0x102 or READB 0x100 → O_hit=0 even when 0x100 is cached, no state change.
- Parameter sweep: SETS=2, CACHE_ABITS=16 → clear takes 2 cycles, tag width 13. The eviction order from the two-way conflict scenario still holds.
